// File: rtl/sram22_pkg.sv
// Shared constants, FSM state type and lane-merge helper for the sram22 behavioural macros.
package sram22_pkg;

  localparam int unsigned RDW_HOLD          = 0;
  localparam int unsigned RDW_WRITE_THROUGH = 1;
  localparam int unsigned MAX_READ_LATENCY  = 4;

  // Widest word the merge helper handles; callers zero-extend into it and truncate back.
  localparam int unsigned MAX_DATA_WIDTH = 1024;

  typedef logic [MAX_DATA_WIDTH-1:0] word_max_t;

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_READY
  } state_e;

  // Bitwise merge: bits set in bit_mask take new_w, the rest keep old_w.
  function automatic word_max_t lane_merge(word_max_t old_w, word_max_t new_w, word_max_t bit_mask);
    return (old_w & ~bit_mask) | (new_w & bit_mask);
  endfunction

endpackage

// File: rtl/sram22_param_sram_if.sv
// Request/response bundle between an SRAM user (master) and the SRAM model (slave).
interface sram22_param_sram_if #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WMASK_WIDTH = 8
);

  logic                   ce;
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic                   busy;

  modport master (
    output ce, we, wmask, addr, din,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  ce, we, wmask, addr, din,
    output dout, dout_valid, busy
  );

endinterface

// File: rtl/sram22_rd_pipe.sv
// Read-response delay line: LATENCY register stages of data + valid.
// Data registers load only when a valid response enters them, so the last
// stage holds the most recent response between strobes.
module sram22_rd_pipe #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] data_q  [LATENCY];
  logic             valid_q [LATENCY];

  // Shift responses one stage per edge; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/sram22_param_sram.sv
// Parametrised single-port SRAM behavioural model with lane masks, read
// pipeline, read-during-write mode and post-reset clear sweep.
module sram22_param_sram
  import sram22_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned WMASK_WIDTH    = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = RDW_HOLD,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic               clk,
  input logic               rst,
  sram22_param_sram_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LW    = DATA_WIDTH / WMASK_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy_q, busy_d;
  logic                  clr_en_c;

  logic                  accept_c;
  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic [DATA_WIDTH-1:0] bit_mask_c;
  logic [DATA_WIDTH-1:0] merged_c;
  logic                  pipe_in_valid_c;
  logic [DATA_WIDTH-1:0] pipe_in_data_c;
  logic                  pipe_out_valid;
  logic [DATA_WIDTH-1:0] pipe_out_data;

  // Clear-sweep FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
      busy_q     <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  // Sweep walks every address once, then releases busy.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    clr_en_c   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_en_c   = !rst;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == '1) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Expand per-lane enables into a per-bit mask.
  always_comb begin
    bit_mask_c = '0;
    for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
      bit_mask_c[i*LW +: LW] = {LW{bus.wmask[i]}};
    end
  end

  // Request decode: read word, merged write word and pipeline entry.
  always_comb begin
    accept_c        = bus.ce && !busy_q && !rst;
    wr_en_c         = accept_c && bus.we;
    rd_word_c       = mem[bus.addr];
    merged_c        = DATA_WIDTH'(lane_merge(word_max_t'(rd_word_c),
                                             word_max_t'(bus.din),
                                             word_max_t'(bit_mask_c)));
    pipe_in_valid_c = accept_c && (!bus.we || (RDW_MODE == RDW_WRITE_THROUGH));
    pipe_in_data_c  = bus.we ? merged_c : rd_word_c;
  end

  // Array update: clear sweep or accepted masked write (mutually exclusive via busy).
  always_ff @(posedge clk) begin
    if (clr_en_c) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_en_c) begin
      mem[bus.addr] <= merged_c;
    end
  end

  sram22_rd_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pipe_in_valid_c),
    .in_data   (pipe_in_data_c),
    .out_valid (pipe_out_valid),
    .out_data  (pipe_out_data)
  );

  assign bus.dout       = pipe_out_data;
  assign bus.dout_valid = pipe_out_valid;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sram22_param_sram.sv
// Directed bench for sram22_param_sram: three instances (default, 3-cycle
// latency, write-through) sharing clock and reset.
module tb_sram22_param_sram;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram22_param_sram_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .WMASK_WIDTH(8)) bus0 ();
  sram22_param_sram_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .WMASK_WIDTH(8)) bus1 ();
  sram22_param_sram_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8), .WMASK_WIDTH(8)) bus2 ();

  sram22_param_sram #(.READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  sram22_param_sram #(.READ_LATENCY(3), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );
  sram22_param_sram #(.READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  n;
  logic seen_valid;

  initial begin
    rst = 1'b1;
    bus0.ce = 0; bus0.we = 0; bus0.wmask = '0; bus0.addr = '0; bus0.din = '0;
    bus1.ce = 0; bus1.we = 0; bus1.wmask = '0; bus1.addr = '0; bus1.din = '0;
    bus2.ce = 0; bus2.we = 0; bus2.wmask = '0; bus2.addr = '0; bus2.din = '0;

    // Reset for two edges
    tick();
    tick();
    check("rst_busy0", 64'(bus0.busy), 64'd1);
    check("rst_busy1", 64'(bus1.busy), 64'd1);
    check("rst_dout0", bus0.dout, 64'd0);
    check("rst_valid0", 64'(bus0.dout_valid), 64'd0);

    // Release reset; hammer u0 with a write to addr 3 while busy
    rst = 1'b0;
    bus0.ce = 1; bus0.we = 1; bus0.wmask = 8'hFF; bus0.addr = 8'd3; bus0.din = 64'h55;
    n = 0;
    seen_valid = 1'b0;
    while (n < 1000) begin
      tick();
      n++;
      if (n == 5) bus0.ce = 0;
      if (bus0.dout_valid || bus1.dout_valid || bus2.dout_valid) seen_valid = 1'b1;
      if (!bus0.busy) break;
    end
    check("busy_cycles", 64'(n), 64'd256);
    check("no_valid_during_sweep", 64'(seen_valid), 64'd0);
    check("busy1_done", 64'(bus1.busy), 64'd0);
    check("busy2_done", 64'(bus2.busy), 64'd0);

    // Write during busy must have been dropped
    bus0.ce = 1; bus0.we = 0; bus0.addr = 8'd3;
    tick();
    bus0.ce = 0;
    check("rd3_valid", 64'(bus0.dout_valid), 64'd1);
    check("rd3_data", bus0.dout, 64'd0);
    tick();
    check("rd3_strobe_one", 64'(bus0.dout_valid), 64'd0);

    // Cleared word read
    bus0.ce = 1; bus0.we = 0; bus0.addr = 8'hA5;
    tick();
    bus0.ce = 0;
    check("rdA5_valid", 64'(bus0.dout_valid), 64'd1);
    check("rdA5_data", bus0.dout, 64'd0);
    tick();
    check("rdA5_strobe_one", 64'(bus0.dout_valid), 64'd0);

    // Masked writes then readback on u0 (HOLD: writes give no response)
    bus0.ce = 1; bus0.we = 1; bus0.addr = 8'h10; bus0.wmask = 8'hFF; bus0.din = 64'h1122334455667788;
    tick();
    check("wr_full_novalid", 64'(bus0.dout_valid), 64'd0);
    bus0.wmask = 8'h0F; bus0.din = 64'hFFFFFFFFFFFFFFFF;
    tick();
    check("wr_half_novalid", 64'(bus0.dout_valid), 64'd0);
    check("wr_hold_dout", bus0.dout, 64'd0);
    bus0.wmask = 8'h00; bus0.din = 64'h0;
    tick();
    bus0.we = 0;
    tick();
    bus0.ce = 0;
    check("rd10_valid", 64'(bus0.dout_valid), 64'd1);
    check("rd10_data", bus0.dout, 64'h11223344FFFFFFFF);

    // HOLD mode: partial write to addr 5 produces nothing, dout held
    bus0.ce = 1; bus0.we = 1; bus0.addr = 8'd5; bus0.wmask = 8'h01; bus0.din = 64'hAB;
    tick();
    bus0.ce = 0;
    check("hold_novalid", 64'(bus0.dout_valid), 64'd0);
    check("hold_dout", bus0.dout, 64'h11223344FFFFFFFF);

    // Preload u1 addrs 1..3
    bus1.ce = 1; bus1.we = 1; bus1.wmask = 8'hFF;
    bus1.addr = 8'd1; bus1.din = 64'hA; tick();
    bus1.addr = 8'd2; bus1.din = 64'hB; tick();
    bus1.addr = 8'd3; bus1.din = 64'hC; tick();
    check("lat3_wr_novalid", 64'(bus1.dout_valid), 64'd0);

    // Back-to-back reads with latency 3
    bus1.we = 0;
    bus1.addr = 8'd1; tick();
    check("lat3_e1_valid", 64'(bus1.dout_valid), 64'd0);
    bus1.addr = 8'd2; tick();
    check("lat3_e2_valid", 64'(bus1.dout_valid), 64'd0);
    bus1.addr = 8'd3; tick();
    bus1.ce = 0;
    check("lat3_r1_valid", 64'(bus1.dout_valid), 64'd1);
    check("lat3_r1_data", bus1.dout, 64'hA);
    tick();
    check("lat3_r2_valid", 64'(bus1.dout_valid), 64'd1);
    check("lat3_r2_data", bus1.dout, 64'hB);
    tick();
    check("lat3_r3_valid", 64'(bus1.dout_valid), 64'd1);
    check("lat3_r3_data", bus1.dout, 64'hC);
    tick();
    check("lat3_idle_valid", 64'(bus1.dout_valid), 64'd0);
    check("lat3_idle_hold", bus1.dout, 64'hC);

    // Write-through mode on u2
    bus2.ce = 1; bus2.we = 1; bus2.addr = 8'd5; bus2.wmask = 8'h01; bus2.din = 64'hAB;
    tick();
    check("wt1_valid", 64'(bus2.dout_valid), 64'd1);
    check("wt1_data", bus2.dout, 64'h00000000000000AB);
    bus2.wmask = 8'h02; bus2.din = 64'hFFFFFFFFFFFF12FF;
    tick();
    bus2.ce = 0;
    check("wt2_valid", 64'(bus2.dout_valid), 64'd1);
    check("wt2_data", bus2.dout, 64'h00000000000012AB);
    tick();
    check("wt_idle_valid", 64'(bus2.dout_valid), 64'd0);
    check("wt_idle_hold", bus2.dout, 64'h00000000000012AB);

    // Reset kills an in-flight u1 read
    bus1.ce = 1; bus1.we = 0; bus1.addr = 8'd2;
    tick();
    bus1.ce = 0;
    rst = 1'b1;
    tick();
    check("kill_valid", 64'(bus1.dout_valid), 64'd0);
    check("kill_dout", bus1.dout, 64'd0);
    check("kill_busy", 64'(bus0.busy), 64'd1);
    rst = 1'b0;

    // Run the sweep to address 100, checking the killed read never surfaces
    seen_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus1.dout_valid) seen_valid = 1'b1;
    end
    check("kill_no_late_valid", 64'(seen_valid), 64'd0);
    check("mid_sweep_busy", 64'(bus0.busy), 64'd1);

    // Restart mid-sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (n < 1000) begin
      tick();
      n++;
      if (!bus0.busy) break;
    end
    check("restart_busy_cycles", 64'(n), 64'd256);

    // Sweep zeroed previously written word
    bus0.ce = 1; bus0.we = 0; bus0.addr = 8'h10;
    tick();
    bus0.ce = 0;
    check("post_clear_valid", 64'(bus0.dout_valid), 64'd1);
    check("post_clear_data", bus0.dout, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
